// File: rtl/fir_stream.sv
// fir_stream -- streaming direct-form FIR filter with a runtime-writable
// coefficient bank.
//
// Optional build macro: FIR_STREAM_SAT_EN
//   defined   : output saturates at 2^OUT_W-1 and io_sat flags clipped results
//   undefined : output wraps modulo 2^OUT_W and io_sat stays 0
//
// Ports
//   clock        : sole clock, rising edge
//   reset        : asynchronous active-high reset
//   io_in_valid  : sample strobe; the delay line advances only when high
//   io_in        : sample value (unsigned, DATA_W)
//   io_clear     : synchronous flush of delay line and pipeline (coefs kept)
//   io_coef_we   : coefficient write enable
//   io_coef_addr : coefficient index; writes at or above TAPS are ignored
//   io_coef_data : coefficient value (unsigned, COEF_W)
//   io_out_valid : one-cycle result strobe, two edges after the sample
//   io_out       : filtered result, held while io_out_valid is low
//   io_sat       : result was clipped (saturating build only)
//
// Pipeline
//   edge 1 : delay line shifts, per-tap products registered (vld_pipe[1])
//   edge 2 : sum of products shifted/reduced into io_out (io_out_valid)

// Per-tap product register: registers x*c whenever a sample is accepted.
module fir_stream_tap #(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       en,
   input  logic [DATA_W-1:0]          x,
   input  logic [COEF_W-1:0]          c,
   output logic [DATA_W+COEF_W-1:0]   prod
);
   localparam int PW = DATA_W + COEF_W;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)   prod <= '0;
      else if (en) prod <= PW'(x) * PW'(c);
   end
endmodule

module fir_stream #(
   parameter int DATA_W = 8,
   parameter int COEF_W = 8,
   parameter int TAPS   = 4,
   parameter int OUT_W  = 8,
   parameter int SHIFT  = 0
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      io_in_valid,
   input  logic [DATA_W-1:0]         io_in,
   input  logic                      io_clear,
   input  logic                      io_coef_we,
   input  logic [$clog2(TAPS)-1:0]   io_coef_addr,
   input  logic [COEF_W-1:0]         io_coef_data,
   output logic                      io_out_valid,
   output logic [OUT_W-1:0]          io_out,
   output logic                      io_sat
);
   localparam int STAGES = 2;
   localparam int PW     = DATA_W + COEF_W;
   localparam int ACC_W  = PW + $clog2(TAPS);
   // Reduction width: wide enough for the accumulator and for one bit above
   // OUT_W, so the clamp compare is meaningful for any parameter mix.
   localparam int RW     = (ACC_W > OUT_W) ? ACC_W : OUT_W + 1;
   localparam logic [RW-1:0] OUT_MAX = {{(RW-OUT_W){1'b0}}, {OUT_W{1'b1}}};

   logic [TAPS-1:0][DATA_W-1:0] dly, dly_nxt;
   logic [TAPS-1:0][COEF_W-1:0] coef;
   logic [TAPS-1:0][PW-1:0]     prod;
   logic [STAGES:1]             vld_pipe;
   logic                        accept;
   logic [ACC_W-1:0]            acc;
   logic [RW-1:0]               shifted;
   logic [OUT_W-1:0]            res;
   logic                        res_sat;

   // Clear wins over a simultaneous sample; that sample is discarded.
   assign accept = io_in_valid && !io_clear;

   // Post-shift view of the delay line; the products are formed from it so
   // the newest sample lands in tap 0 on the same edge it is accepted.
   always_comb begin
      dly_nxt    = dly;
      dly_nxt[0] = io_in;
      for (int k = 1; k < TAPS; k++) dly_nxt[k] = dly[k-1];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)         dly <= '0;
      else if (io_clear) dly <= '0;
      else if (accept)   dly <= dly_nxt;
   end

   // Coefficient bank; the taps see the pre-edge value, so a sample accepted
   // with a simultaneous write uses the old coefficient.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         coef <= '0;
      else if (io_coef_we && (int'(io_coef_addr) < TAPS))
         coef[io_coef_addr] <= io_coef_data;
   end

   for (genvar k = 0; k < TAPS; k++) begin : g_tap
      fir_stream_tap #(.DATA_W(DATA_W), .COEF_W(COEF_W)) u_tap (
         .clock (clock),
         .reset (reset),
         .en    (accept),
         .x     (dly_nxt[k]),
         .c     (coef[k]),
         .prod  (prod[k])
      );
   end

   always_comb begin
      acc = '0;
      for (int k = 0; k < TAPS; k++) acc = acc + ACC_W'(prod[k]);
   end

   assign shifted = RW'(acc) >> SHIFT;

`ifdef FIR_STREAM_SAT_EN
   assign res_sat = (shifted > OUT_MAX);
   assign res     = res_sat ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
`else
   logic unused_hi;
   assign unused_hi = ^{shifted[RW-1:OUT_W], OUT_MAX};
   assign res_sat   = 1'b0;
   assign res       = shifted[OUT_W-1:0];
`endif

   // Valid shift register; clear kills whatever is in flight, including the
   // result that would otherwise appear right after the clear edge.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)         vld_pipe <= '0;
      else if (io_clear) vld_pipe <= '0;
      else               vld_pipe <= {vld_pipe[STAGES-1:1], accept};
   end

   assign io_out_valid = vld_pipe[STAGES];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         io_out <= '0;
         io_sat <= 1'b0;
      end else if (vld_pipe[1] && !io_clear) begin
         io_out <= res;
         io_sat <= res_sat;
      end else begin
         io_sat <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fir_stream.sv
// Scoreboard bench for fir_stream. DUT 0: TAPS=4, DATA_W=COEF_W=4, OUT_W=8,
// SHIFT=0. DUT 1: same but SHIFT=2, fed samples only during the step test.
module tb_fir_stream;
   typedef struct {
      logic [7:0] out;
      logic       sat;
      int         due;
      string      name;
   } exp_t;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       in_valid = 1'b0, in_valid2 = 1'b0, clr = 1'b0, we = 1'b0;
   logic [3:0] in_x = '0, cdata = '0;
   logic [1:0] addr = '0;
   logic       vld0, vld1, sat0, sat1;
   logic [7:0] out0, out1;

   exp_t       q0[$];
   exp_t       q1[$];
   logic [7:0] hold[2];
   int         cyc = 0;
   int         n_cmp = 0, n_err = 0;
   logic [7:0] ovf_o[4];
   logic       ovf_s[4];

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   fir_stream #(.DATA_W(4), .COEF_W(4), .TAPS(4), .OUT_W(8), .SHIFT(0)) dut0 (
      .clock(clock), .reset(reset), .io_in_valid(in_valid), .io_in(in_x),
      .io_clear(clr), .io_coef_we(we), .io_coef_addr(addr), .io_coef_data(cdata),
      .io_out_valid(vld0), .io_out(out0), .io_sat(sat0));

   fir_stream #(.DATA_W(4), .COEF_W(4), .TAPS(4), .OUT_W(8), .SHIFT(2)) dut1 (
      .clock(clock), .reset(reset), .io_in_valid(in_valid2), .io_in(in_x),
      .io_clear(clr), .io_coef_we(we), .io_coef_addr(addr), .io_coef_data(cdata),
      .io_out_valid(vld1), .io_out(out1), .io_sat(sat1));

   task automatic chk(input string n, input logic [7:0] got, input logic [7:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", n, got, exp);
      end
   endtask

   // One driven cycle, applied just after a falling edge.
   task automatic drive(input logic v, input logic v2, input logic [3:0] x,
                        input logic c, input logic w, input logic [1:0] a,
                        input logic [3:0] d);
      @(negedge clock);
      in_valid = v; in_valid2 = v2; in_x = x; clr = c; we = w; addr = a; cdata = d;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic push(input int i, input logic [7:0] o, input logic s, input string n);
      exp_t e;
      e.out = o; e.sat = s; e.due = cyc + 2; e.name = n;
      if (i == 0) q0.push_back(e);
      else        q1.push_back(e);
   endtask

   task automatic mon(input int i, input logic v, input logic [7:0] o, input logic s);
      exp_t e;
      bit   have;
      have = 1'b0;
      if (v) begin
         if (i == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
         if (i == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
         n_cmp++;
         if (!have) begin
            n_err++;
            $display("FAIL unexpected_valid dut%0d: got out=%0d, expected no result", i, o);
         end else begin
            if (o !== e.out || s !== e.sat || cyc != e.due) begin
               n_err++;
               $display("FAIL %s dut%0d: got out=%0d sat=%0d cyc=%0d, expected out=%0d sat=%0d cyc=%0d",
                        e.name, i, o, s, cyc, e.out, e.sat, e.due);
            end
            hold[i] = e.out;
         end
      end else begin
         n_cmp++;
         if (o !== hold[i] || s !== 1'b0) begin
            n_err++;
            $display("FAIL hold dut%0d: got out=%0d sat=%0d, expected out=%0d sat=0", i, o, s, hold[i]);
         end
      end
   endtask

   always @(negedge clock) begin
      if (!reset) begin
         mon(0, vld0, out0, sat0);
         mon(1, vld1, out1, sat1);
      end
   end

   initial begin
      string nm;
      hold[0] = 0; hold[1] = 0;
`ifdef FIR_STREAM_SAT_EN
      ovf_o = '{225, 255, 255, 255}; ovf_s = '{0, 1, 1, 1};
`else
      ovf_o = '{225, 194, 163, 132}; ovf_s = '{0, 0, 0, 0};
`endif
      #12;
      chk("reset_out", out0, 0);
      chk("reset_valid", {7'd0, vld0}, 0);
      chk("reset_sat", {7'd0, sat0}, 0);
      @(negedge clock); reset = 1'b0;

      // coefficients {1,2,3,4}
      for (int k = 0; k < 4; k++) drive(0, 0, 0, 0, 1, 2'(k), 4'(k + 1));

      // step response; DUT 1 (SHIFT=2) takes the first four samples
      for (int k = 0; k < 6; k++) begin
         drive(1, k < 4, 1, 0, 0, 0, 0);
         nm = $sformatf("step%0d", k);
         case (k)
            0: push(0, 1, 0, nm);
            1: push(0, 3, 0, nm);
            2: push(0, 6, 0, nm);
            default: push(0, 10, 0, nm);
         endcase
         case (k)
            0: push(1, 0, 0, nm);
            1: push(1, 0, 0, nm);
            2: push(1, 1, 0, nm);
            3: push(1, 2, 0, nm);
            default: ;
         endcase
      end
      idle(3);

      // gaps: valid 1,0,1,0
      drive(0, 0, 0, 1, 0, 0, 0);
      drive(1, 0, 1, 0, 0, 0, 0); push(0, 1, 0, "gap0");
      drive(0, 0, 1, 0, 0, 0, 0);
      drive(1, 0, 1, 0, 0, 0, 0); push(0, 3, 0, "gap1");
      drive(0, 0, 1, 0, 0, 0, 0);
      idle(3);

      // overflow: c=15, x=15
      drive(0, 0, 0, 1, 0, 0, 0);
      for (int k = 0; k < 4; k++) drive(0, 0, 0, 0, 1, 2'(k), 15);
      for (int k = 0; k < 4; k++) begin
         drive(1, 0, 15, 0, 0, 0, 0);
         push(0, ovf_o[k], ovf_s[k], $sformatf("ovf%0d", k));
      end
      idle(3);

      // coefficient update alongside a sample
      drive(0, 0, 0, 1, 0, 0, 0);
      for (int k = 0; k < 4; k++) drive(0, 0, 0, 0, 1, 2'(k), 4'(k + 1));
      drive(1, 0, 1, 0, 1, 0, 5); push(0, 1, 0, "coef_old");
      drive(1, 0, 1, 0, 0, 0, 0); push(0, 7, 0, "coef_new");
      idle(3);

      // clear with two samples in flight (second one arrives with the clear)
      drive(0, 0, 0, 1, 0, 0, 0);
      drive(1, 0, 1, 0, 0, 0, 0);
      drive(1, 0, 1, 1, 0, 0, 0);
      idle(3);
      drive(1, 0, 1, 0, 0, 0, 0); push(0, 5, 0, "after_clear");
      idle(3);

      // async reset mid-stream
      drive(1, 0, 3, 0, 0, 0, 0);
      drive(1, 0, 3, 0, 0, 0, 0);
      @(posedge clock); #2;
      reset = 1'b1;
      #1;
      chk("async_out", out0, 0);
      chk("async_valid", {7'd0, vld0}, 0);
      chk("async_sat", {7'd0, sat0}, 0);
      chk("async_out_shift", out1, 0);
      q0.delete(); q1.delete();
      hold[0] = 0; hold[1] = 0;
      @(negedge clock); reset = 1'b0;
      in_valid = 0; in_valid2 = 0; clr = 0; we = 0;
      drive(0, 0, 0, 0, 1, 0, 3);
      drive(1, 0, 2, 0, 0, 0, 0); push(0, 6, 0, "post_reset");
      idle(1);

      // drain with a bounded wait
      for (int i = 0; i < 20 && (q0.size() + q1.size()) > 0; i++) @(negedge clock);
      idle(1);
      chk("drain_dut0", 8'(q0.size()), 0);
      chk("drain_dut1", 8'(q1.size()), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/fir_stream.md
FIR_STREAM -- requirements
Module: fir_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8, unsigned sample width.
REQ-002 SHALL have parameter COEF_W, default 8, unsigned coefficient width.
REQ-003 SHALL have parameter TAPS, default 4 (range 2..32), number of filter taps.
REQ-004 SHALL have parameter OUT_W, default 8, output width.
REQ-005 SHALL have parameter SHIFT, default 0, right shift applied to the accumulator before output.
REQ-006 SHALL have port clock, input, 1, sole clock; all logic on the rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port io_in_valid, input, 1, sample strobe.
REQ-009 SHALL have port io_in, input, DATA_W, sample value.
REQ-010 SHALL have port io_clear, input, 1, synchronous flush of the delay line and pipeline.
REQ-011 SHALL have port io_coef_we, input, 1, coefficient write enable.
REQ-012 SHALL have port io_coef_addr, input, clog2(TAPS), coefficient index.
REQ-013 SHALL have port io_coef_data, input, COEF_W, coefficient value.
REQ-014 SHALL have port io_out_valid, output, 1, result strobe.
REQ-015 SHALL have port io_out, output, OUT_W, filtered result.
REQ-016 SHALL have port io_sat, output, 1, high with io_out_valid when the result was clipped (SAT build only, else 0).

Function
REQ-017 SHALL compute y[n] = sum over k=0..TAPS-1 of c[k]*x[n-k]; x[n] is the current sample; samples not yet received count as 0.
REQ-018 SHALL keep the accumulator at full precision: DATA_W+COEF_W+clog2(TAPS) bits, no intermediate overflow.
REQ-019 SHALL advance the delay line only on cycles where io_in_valid=1; idle cycles leave it unchanged.
REQ-020 SHALL use two register stages: edge 1 registers the delay line and the per-tap products; edge 2 registers the sum into io_out.
REQ-021 SHALL assert io_out_valid for exactly one cycle, 2 clock edges after each accepted sample; back-to-back samples give back-to-back results.
REQ-022 SHALL hold io_out at its last value while io_out_valid=0.
REQ-023 SHALL write c[io_coef_addr]=io_coef_data at the edge where io_coef_we=1.
REQ-024 SHALL compute a sample accepted in the same cycle as a coefficient write with the old coefficient.
REQ-025 SHALL ignore a write when io_coef_addr>=TAPS.
REQ-026 SHALL, on io_clear=1, zero the delay line, drop any in-flight results (no io_out_valid next cycle) and leave the coefficients intact.
REQ-027 SHALL give io_clear priority over a simultaneous io_in_valid; that sample is discarded.
REQ-028 SHALL form the output as accumulator>>SHIFT (floor), then reduce it to OUT_W bits per the Configuration section.

Reset
REQ-029 SHALL, while reset=1, asynchronously clear the delay line, pipeline valids, io_out, io_out_valid and io_sat to 0.
REQ-030 SHALL reset coefficients to c[k]=0 for all k.
REQ-031 SHALL, on reset mid-stream, lose in-flight results; the first io_out_valid comes 2 edges after the first sample following deassertion.

Configuration
REQ-032 SHALL, when macro FIR_STREAM_SAT_EN is defined, clamp a shifted value above 2^OUT_W-1 to 2^OUT_W-1 and set io_sat=1 for that result.
REQ-033 SHALL, when FIR_STREAM_SAT_EN is undefined, truncate to the low OUT_W bits (modulo wrap) and tie io_sat to 0.

Verification
REQ-034 SHALL cover step response: TAPS=4, DATA_W=COEF_W=4, OUT_W=8, c={1,2,3,4}, io_in=1 for 6 valid cycles -> io_out 1,3,6,10,10,10, each 2 edges after its sample.
REQ-035 SHALL cover gaps: same setup with io_in_valid toggling 1,0,1,0 -> results 1 then 3 on valid cycles only; io_out held between.
REQ-036 SHALL cover overflow: c={15,15,15,15}, io_in=15 for 4 samples -> 4th result 900; SAT build gives 255 with io_sat=1, non-SAT gives 132 with io_sat=0.
REQ-037 SHALL cover coefficient update: write c[0]=5 in the same cycle as a sample -> that result uses the old c[0]; the next sample uses 5.
REQ-038 SHALL cover clear and reset: io_clear asserted with 2 results in flight -> no io_out_valid for them; the next sample 1 gives io_out=c[0]. Async reset mid-stream -> outputs 0 immediately, before the next clock edge.
REQ-039 SHALL cover SHIFT=2 with the step stimulus -> io_out 0,0,1,2.
